// File: rtl/cpu6_decode_q.sv
// cpu6_decode_q: registered, queued RV32I main-decode stage between IF and EX.
//
// Decodes each instruction presented by IF, stores the decoded control bundle
// with its PC in a small FIFO, and presents the head entry to EX. Both sides
// use valid/ready. A flush empties the queue and drops any same-cycle input.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   flush                discard queue contents and same-cycle input/pop
//   in_valid/in_ready    IF handshake; in_instr, in_pc carry the instruction
//   out_valid/out_ready  EX handshake; out_* carry the head decoded bundle
//   illegal_cnt          saturating count of accepted illegal instructions
module cpu6_decode_q #(
   parameter int DEPTH          = 2,
   parameter int PCW            = 32,
   parameter int ILLEGAL_AS_NOP = 0,
   parameter int CNTW           = 16
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PCW-1:0]  in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PCW-1:0]  out_pc,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic            out_memtoreg,
   output logic            out_memwrite,
   output logic            out_alusrc,
   output logic            out_regwrite,
   output logic [2:0]      out_branchtype,
   output logic [1:0]      out_jump,
   output logic [3:0]      out_aluop,
   output logic [2:0]      out_immtype,
   output logic            out_illegal,
   output logic [CNTW-1:0] illegal_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] BT_NONE  = 3'b010;
   localparam logic [2:0] IMM_I    = 3'b000;
   localparam logic [2:0] IMM_S    = 3'b001;
   localparam logic [2:0] IMM_B    = 3'b010;
   localparam logic [2:0] IMM_U    = 3'b011;
   localparam logic [2:0] IMM_J    = 3'b100;
   localparam logic [2:0] IMM_NONE = 3'b111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_PASS = 4'b1111;

   typedef struct packed {
      logic [PCW-1:0] pc;
      logic [4:0]     rd;
      logic [4:0]     rs1;
      logic [4:0]     rs2;
      logic           memtoreg;
      logic           memwrite;
      logic           alusrc;
      logic           regwrite;
      logic [2:0]     branchtype;
      logic [1:0]     jump;
      logic [3:0]     aluop;
      logic [2:0]     immtype;
      logic           illegal;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        dec;
   entry_t        head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          legal;
   logic          accept, pop;

   wire [6:0] opcode = in_instr[6:0];
   wire [2:0] funct3 = in_instr[14:12];
   wire [6:0] funct7 = in_instr[31:25];

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Ready depends only on registered count, so EX stalls never reach IF
   // combinationally. Held low while reset is asserted.
   assign in_ready  = resetn & (count < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign accept    = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_comb begin
      dec            = '0;
      dec.pc         = in_pc;
      dec.rd         = in_instr[11:7];
      dec.rs1        = in_instr[19:15];
      dec.rs2        = in_instr[24:20];
      dec.branchtype = BT_NONE;
      dec.immtype    = IMM_NONE;
      legal          = 1'b1;
      case (opcode)
         OPC_LOAD: begin
            // lb lh lw lbu lhu only
            legal        = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            dec.memtoreg = 1'b1;
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.immtype  = IMM_I;
         end
         OPC_STORE: begin
            legal        = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
            dec.memwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.immtype  = IMM_S;
         end
         OPC_IMM: begin
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.immtype  = IMM_I;
            dec.aluop    = {1'b0, funct3};
            // Shift-immediates reuse funct7 as a shift-type selector.
            if (funct3 == 3'b001) begin
               legal = (funct7 == F7_BASE);
            end else if (funct3 == 3'b101) begin
               legal        = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               dec.aluop[3] = funct7[5];
            end
         end
         OPC_OP: begin
            dec.regwrite = 1'b1;
            dec.aluop    = {funct7[5], funct3};
            legal        = (funct7 == F7_BASE) ||
                           ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         OPC_BRANCH: begin
            legal          = (funct3[2:1] != 2'b01);
            dec.branchtype = funct3;
            dec.aluop      = ALU_SUB;
            dec.immtype    = IMM_B;
         end
         OPC_JAL: begin
            dec.regwrite = 1'b1;
            dec.jump     = 2'b01;
            dec.immtype  = IMM_J;
         end
         OPC_JALR: begin
            legal        = (funct3 == 3'b000);
            dec.regwrite = 1'b1;
            dec.jump     = 2'b10;
            dec.alusrc   = 1'b1;
            dec.immtype  = IMM_I;
         end
         OPC_LUI: begin
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.aluop    = ALU_PASS;
            dec.immtype  = IMM_U;
         end
         OPC_AUIPC: begin
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.immtype  = IMM_U;
         end
         default: legal = 1'b0;
      endcase

      // Illegal entries never write, branch or jump. With ILLEGAL_AS_NOP=0
      // the whole bundle collapses to the canonical bubble; with 1 the
      // non-side-effecting fields are kept for debug visibility.
      if (!legal) begin
         dec.illegal    = 1'b1;
         dec.memtoreg   = 1'b0;
         dec.memwrite   = 1'b0;
         dec.regwrite   = 1'b0;
         dec.branchtype = BT_NONE;
         dec.jump       = 2'b00;
         if (ILLEGAL_AS_NOP == 0) begin
            dec.rd      = '0;
            dec.rs1     = '0;
            dec.rs2     = '0;
            dec.alusrc  = 1'b0;
            dec.aluop   = '0;
            dec.immtype = IMM_NONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= dec;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         illegal_cnt <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= ptr_next(wr_ptr);
         if (pop)    rd_ptr <= ptr_next(rd_ptr);
         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (accept && dec.illegal && (illegal_cnt != {CNTW{1'b1}}))
            illegal_cnt <= illegal_cnt + CNTW'(1);
      end
   end

   // An empty queue presents the bubble bundle rather than stale storage.
   always_comb begin
      head = mem[rd_ptr];
      if (!out_valid) begin
         head            = '0;
         head.branchtype = BT_NONE;
         head.immtype    = IMM_NONE;
      end
   end

   assign out_pc         = head.pc;
   assign out_rd         = head.rd;
   assign out_rs1        = head.rs1;
   assign out_rs2        = head.rs2;
   assign out_memtoreg   = head.memtoreg;
   assign out_memwrite   = head.memwrite;
   assign out_alusrc     = head.alusrc;
   assign out_regwrite   = head.regwrite;
   assign out_branchtype = head.branchtype;
   assign out_jump       = head.jump;
   assign out_aluop      = head.aluop;
   assign out_immtype    = head.immtype;
   assign out_illegal    = head.illegal;

endmodule

// File: tb/tb_cpu6_decode_q.sv
module tb_cpu6_decode_q;
   localparam int DEPTH = 3;
   localparam int PCW   = 32;
   localparam int CNTW  = 3;
   localparam int MAXC  = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [31:0]     in_instr = '0;
   logic [PCW-1:0]  in_pc = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [PCW-1:0]  out_pc;
   logic [4:0]      out_rd, out_rs1, out_rs2;
   logic            out_memtoreg, out_memwrite, out_alusrc, out_regwrite;
   logic [2:0]      out_branchtype;
   logic [1:0]      out_jump;
   logic [3:0]      out_aluop;
   logic [2:0]      out_immtype;
   logic            out_illegal;
   logic [CNTW-1:0] illegal_cnt;

   cpu6_decode_q #(.DEPTH(DEPTH), .PCW(PCW), .ILLEGAL_AS_NOP(0), .CNTW(CNTW)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_memtoreg(out_memtoreg), .out_memwrite(out_memwrite),
      .out_alusrc(out_alusrc), .out_regwrite(out_regwrite),
      .out_branchtype(out_branchtype), .out_jump(out_jump), .out_aluop(out_aluop),
      .out_immtype(out_immtype), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rd, rs1, rs2;
      logic       mtr, mw, as, rw;
      logic [2:0] bt;
      logic [1:0] jmp;
      logic [3:0] op;
      logic [2:0] it;
      logic       ill;
   } bun_t;

   bun_t        q[$];
   logic [31:0] pcq[$];
   int          cnt_m = 0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Reference decode, straight from the instruction-class table.
   function automatic bun_t ref_dec(input logic [31:0] i);
      bun_t       b;
      bit         ok;
      int         f3, f7;
      f3 = int'(i[14:12]);
      f7 = int'(i[31:25]);
      b = '0; b.bt = 3'd2; b.it = 3'd7; ok = 1;
      case (i[6:0])
         7'h03: begin ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                      b.mtr = 1; b.rw = 1; b.as = 1; b.it = 3'd0; end
         7'h23: begin ok = (f3 <= 2); b.mw = 1; b.as = 1; b.it = 3'd1; end
         7'h13: begin b.rw = 1; b.as = 1; b.it = 3'd0; b.op = 4'(f3);
                      if (f3 == 1) ok = (f7 == 0);
                      if (f3 == 5) begin ok = (f7 == 0 || f7 == 32); if (f7 == 32) b.op = 4'd13; end
                end
         7'h33: begin b.rw = 1; b.op = 4'(f3);
                      ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                      if (f7 == 32) b.op = 4'(f3 + 8);
                end
         7'h63: begin ok = (f3 != 2 && f3 != 3); b.bt = 3'(f3); b.op = 4'd8; b.it = 3'd2; end
         7'h6f: begin b.rw = 1; b.jmp = 2'd1; b.it = 3'd4; end
         7'h67: begin ok = (f3 == 0); b.rw = 1; b.jmp = 2'd2; b.as = 1; b.it = 3'd0; end
         7'h37: begin b.rw = 1; b.as = 1; b.op = 4'd15; b.it = 3'd3; end
         7'h17: begin b.rw = 1; b.as = 1; b.it = 3'd3; end
         default: ok = 0;
      endcase
      if (ok) begin
         b.rd = i[11:7]; b.rs1 = i[19:15]; b.rs2 = i[24:20];
      end else begin
         b = '0; b.bt = 3'd2; b.it = 3'd7; b.ill = 1;
      end
      return b;
   endfunction

   function automatic bun_t obs();
      bun_t b;
      b = {out_rd, out_rs1, out_rs2, out_memtoreg, out_memwrite, out_alusrc, out_regwrite,
           out_branchtype, out_jump, out_aluop, out_immtype, out_illegal};
      return b;
   endfunction

   // One clock: drive, compare DUT state with the model, advance the model.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      bit acc, pp;
      bun_t d;
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
      #1;
      chk("in_ready", 64'(in_ready), 64'(resetn && q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("illegal_cnt", 64'(illegal_cnt), 64'(cnt_m));
      if (q.size() != 0) chk("head", {out_pc, obs()}, {pcq[0], q[0]});
      @(posedge clk);
      if (!resetn) begin
         q.delete(); pcq.delete(); cnt_m = 0;
      end else if (fl) begin
         q.delete(); pcq.delete();
      end else begin
         acc = v && (q.size() < DEPTH);
         pp  = ordy && (q.size() != 0);
         if (pp) begin void'(q.pop_front()); void'(pcq.pop_front()); end
         if (acc) begin
            d = ref_dec(ins);
            q.push_back(d); pcq.push_back(pc);
            if (d.ill && cnt_m < MAXC) cnt_m++;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input logic fl);
      resetn = 1'b0;
      cycle(1'b1, 32'h00500093, 32'h0, 1'b1, fl);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, fl);
      resetn = 1'b1;
   endtask

   function automatic logic [31:0] addi_rd(input int rd);
      logic [31:0] x;
      x = 32'h00500093;
      x[11:7] = 5'(rd);
      return x;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [31:0] x;
      logic [6:0]  opcs [10];
      opcs = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f};
      x = $urandom;
      x[6:0] = opcs[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
         0: x[31:25] = 7'h00;
         1: x[31:25] = 7'h20;
         2: x[31:25] = 7'h01;
         default: ;
      endcase
      if ($urandom_range(0, 30) == 0) x = 32'h0;
      return x;
   endfunction

   initial begin
      // Bring the DUT out of its power-up unknown state before modelling.
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state; reset also wins over a concurrent flush.
      do_reset(1'b1);
      chk("rst_bt", 64'(out_branchtype), 64'd2);
      chk("rst_it", 64'(out_immtype), 64'd7);
      chk("rst_rw", 64'({out_regwrite, out_memwrite, out_illegal, out_jump, out_aluop}), 64'd0);

      // addi x1,x0,5 streamed with out_ready=1
      cycle(1, 32'h00500093, 32'h100, 1, 0);
      chk("addi_v", 64'(out_valid), 64'd1);
      chk("addi_f", 64'({out_regwrite, out_alusrc, out_aluop, out_immtype, out_rd, out_illegal}),
          64'({1'b1, 1'b1, 4'd0, 3'd0, 5'd1, 1'b0}));
      cycle(0, 0, 0, 1, 0);

      // Fill to DEPTH with EX stalled; extra instruction is held.
      for (int k = 0; k < DEPTH; k++) cycle(1, addi_rd(k + 2), 32'h200 + 4 * k, 0, 0);
      chk("full_rdy", 64'(in_ready), 64'd0);
      cycle(1, addi_rd(20), 32'h300, 0, 0);
      cycle(1, addi_rd(20), 32'h300, 1, 0);
      chk("drop_rdy", 64'(in_ready), 64'd1);
      cycle(1, addi_rd(20), 32'h300, 1, 0);
      repeat (DEPTH + 1) cycle(0, 0, 0, 1, 0);

      // Specific decodes.
      cycle(1, 32'h4020D1B3, 32'h400, 0, 0);
      chk("sra", 64'({out_aluop, out_regwrite, out_alusrc, out_immtype}), 64'({4'b1101, 1'b1, 1'b0, 3'd7}));
      cycle(0, 0, 0, 1, 0);
      cycle(1, 32'h0020E463, 32'h404, 0, 0);
      chk("bltu", 64'({out_branchtype, out_aluop, out_immtype, out_regwrite}), 64'({3'b110, 4'b1000, 3'b010, 1'b0}));
      cycle(0, 0, 0, 1, 0);
      cycle(1, 32'h008000EF, 32'h408, 0, 0);
      chk("jal", 64'({out_jump, out_immtype, out_regwrite, out_rd}), 64'({2'b01, 3'b100, 1'b1, 5'd1}));
      cycle(0, 0, 0, 1, 0);
      cycle(1, 32'h000080E7, 32'h40C, 0, 0);
      chk("jalr", 64'({out_jump, out_alusrc, out_immtype}), 64'({2'b10, 1'b1, 3'b000}));
      cycle(0, 0, 0, 1, 0);
      cycle(1, 32'h123450B7, 32'h410, 0, 0);
      chk("lui", 64'({out_aluop, out_immtype, out_alusrc}), 64'({4'b1111, 3'b011, 1'b1}));
      cycle(0, 0, 0, 1, 0);

      // Illegal encodings and counter saturation.
      do_reset(1'b0);
      cycle(1, 32'h00000000, 32'h500, 0, 0);
      chk("ill0", 64'({out_illegal, out_branchtype, out_regwrite}), 64'({1'b1, 3'b010, 1'b0}));
      cycle(0, 0, 0, 1, 0);
      cycle(1, 32'h02208033, 32'h504, 0, 0);
      chk("illmul", 64'({out_illegal, out_branchtype, out_regwrite}), 64'({1'b1, 3'b010, 1'b0}));
      cycle(0, 0, 0, 1, 0);
      chk("cnt2", 64'(illegal_cnt), 64'd2);
      repeat (8) cycle(1, 32'hFFFFFFFF, 32'h508, 1, 0);
      cycle(0, 0, 0, 1, 0);
      chk("cnt_sat", 64'(illegal_cnt), 64'(MAXC));

      // Flush with input and pop in the same cycle.
      cycle(1, addi_rd(3), 32'h600, 0, 0);
      cycle(1, addi_rd(4), 32'h604, 0, 0);
      cycle(1, addi_rd(31), 32'h608, 1, 1);
      chk("fl_v", 64'(out_valid), 64'd0);
      chk("fl_r", 64'(in_ready), 64'd1);
      cycle(1, addi_rd(7), 32'h60C, 0, 0);
      chk("fl_next", 64'({out_rd, out_pc}), 64'({5'd7, 32'h60C}));
      cycle(0, 0, 0, 1, 0);

      // Steady accept+pop at high occupancy; pointers wrap repeatedly.
      cycle(1, addi_rd(1), 32'h700, 0, 0);
      cycle(1, addi_rd(2), 32'h704, 0, 0);
      for (int k = 0; k < 10; k++) cycle(1, addi_rd(k + 3), 32'h708 + 4 * k, 1, 0);
      repeat (DEPTH + 1) cycle(0, 0, 0, 1, 0);

      // Random traffic with occasional flush and reset.
      for (int k = 0; k < 3000; k++) begin
         resetn = ($urandom_range(0, 299) != 0);
         cycle(($urandom_range(0, 3) != 0), rnd_instr(), $urandom,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
      end
      resetn = 1'b1;
      repeat (DEPTH + 1) cycle(0, 0, 0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
